// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the next-PC / branch resolution slice of the RV32I core.
// Holds the branch funct3 encodings, the FSM state type and the default PC constants.
package branch_resolve_unit_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } branch_f3_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } bru_state_e;

endpackage

// File: rtl/branch_resolve_unit_branch_cond.sv
// Branch condition select: maps funct3 and the ALU compare flags to a single cond bit.
// Reserved encodings (010/011) never take.
module branch_cond
    import branch_resolve_unit_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       eq,
    input  logic       lt_s,
    input  logic       ge_s,
    input  logic       lt_u,
    input  logic       ge_u,
    output logic       cond
);

    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = eq;
            F3_BNE:  cond = ~eq;
            F3_BLT:  cond = lt_s;
            F3_BGE:  cond = ge_s;
            F3_BLTU: cond = lt_u;
            F3_BGEU: cond = ge_u;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Next-PC unit: owns the architectural PC, resolves branches and jumps, traps on
// misaligned control-flow targets and keeps a saturating count of taken transfers.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic             stall,
    input  logic             is_branch,
    input  logic             is_jal,
    input  logic             is_jalr,
    input  logic [2:0]       funct3,
    input  logic [31:0]      imm,
    input  logic [31:0]      rs1,
    input  logic             eq,
    input  logic             lt_s,
    input  logic             ge_s,
    input  logic             lt_u,
    input  logic             ge_u,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             taken,
    output logic             trap_pending,
    output logic [31:0]      trap_epc,
    input  logic             trap_ack,
    output logic [CNT_W-1:0] taken_count
);

    bru_state_e       state, state_next;
    logic [31:0]      pc_next, epc_next, target;
    logic [CNT_W-1:0] count_next;
    logic             cond, advance, misaligned;

    branch_cond u_branch_cond (
        .funct3 (funct3),
        .eq     (eq),
        .lt_s   (lt_s),
        .ge_s   (ge_s),
        .lt_u   (lt_u),
        .ge_u   (ge_u),
        .cond   (cond)
    );

    assign pc_plus4     = pc + 32'd4;
    assign trap_pending = (state == ST_TRAP);

    // JALR wins over JAL/branch; JAL and branch share the pc-relative adder.
    assign target     = is_jalr ? ((rs1 + imm) & ~32'h1) : (pc + imm);
    assign taken      = (state == ST_RUN) & instr_valid &
                        (is_jal | is_jalr | (is_branch & cond));
    assign misaligned = taken & target[1];
    assign advance    = instr_valid & ~stall;

    always_comb begin
        state_next = state;
        pc_next    = pc;
        epc_next   = trap_epc;
        count_next = taken_count;
        case (state)
            ST_RUN: begin
                if (advance) begin
                    if (misaligned) begin
                        pc_next    = TRAP_VEC;
                        epc_next   = pc;
                        state_next = ST_TRAP;
                    end else if (taken) begin
                        pc_next = target;
                        if (taken_count != '1) begin
                            count_next = taken_count + CNT_W'(1);
                        end
                    end else begin
                        pc_next = pc_plus4;
                    end
                end
            end
            ST_TRAP: begin
                if (trap_ack) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            pc          <= RESET_PC;
            trap_epc    <= '0;
            taken_count <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            trap_epc    <= epc_next;
            taken_count <= count_next;
        end
    end

endmodule
